// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and requester index encoding for the two-port BRAM arbiter.
package bram_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int RD_LAT  = 1;

    // Values double as the encoding of the priority pointer and the read-return tag
    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_idx_e;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Single-beat request/grant interface between one requester and the BRAM arbiter.
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-input grant logic with a round-robin priority pointer.
// Define BPA_FIXED_PRIO_EN to make R0 always win contention (pointer removed).
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

`ifdef BPA_FIXED_PRIO_EN

    // Fixed priority: R0 over R1, nothing granted while in reset
    always_comb begin
        gnt_o = 2'b00;
        if (rst) begin
            gnt_o = 2'b00;
        end else if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end else begin
            gnt_o = 2'b00;
        end
    end

`else

    req_idx_e prio_q;
    req_idx_e prio_d;

    // Grant selection; after any grant the loser becomes the favoured requester
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (rst) begin
            gnt_o = 2'b00;
        end else begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (prio_q == REQ_R0) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o[0]) begin
                prio_d = REQ_R1;
            end else if (gnt_o[1]) begin
                prio_d = REQ_R0;
            end else begin
                prio_d = prio_q;
            end
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= REQ_R0;
        end else begin
            prio_q <= prio_d;
        end
    end

`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between two requesters; read data returns one cycle after grant.
// Optional BPA_FIXED_PRIO_EN (see rr_arb2) replaces round-robin with fixed R0 priority.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_arbiter_if.slave    r0_if,
    bram_port_arbiter_if.slave    r1_if,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               rd_pend_q;
    logic               rd_pend_d;
    req_idx_e           rd_tag_q;
    req_idx_e           rd_tag_d;

    assign req_s = {r1_if.req, r0_if.req};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_s),
        .gnt_o (gnt_s)
    );

    // RAM port mux and read-return tag capture; idle cycles read address 0
    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = {ADDR_WIDTH{1'b0}};
        ram_din_o  = {DATA_WIDTH{1'b0}};
        rd_pend_d  = 1'b0;
        rd_tag_d   = rd_tag_q;
        case (gnt_s)
            2'b01: begin
                ram_we_o   = r0_if.we;
                ram_addr_o = r0_if.addr;
                ram_din_o  = r0_if.wdata;
                rd_pend_d  = ~r0_if.we;
                rd_tag_d   = REQ_R0;
            end
            2'b10: begin
                ram_we_o   = r1_if.we;
                ram_addr_o = r1_if.addr;
                ram_din_o  = r1_if.wdata;
                rd_pend_d  = ~r1_if.we;
                rd_tag_d   = REQ_R1;
            end
            default: begin
                ram_we_o   = 1'b0;
                ram_addr_o = {ADDR_WIDTH{1'b0}};
                ram_din_o  = {DATA_WIDTH{1'b0}};
                rd_pend_d  = 1'b0;
                rd_tag_d   = rd_tag_q;
            end
        endcase
    end

    // Pending-read register; cleared by reset so an in-flight read is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= REQ_R0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    assign r0_if.gnt    = gnt_s[0];
    assign r1_if.gnt    = gnt_s[1];
    assign r0_if.rvalid = rd_pend_q & (rd_tag_q == REQ_R0);
    assign r1_if.rvalid = rd_pend_q & (rd_tag_q == REQ_R1);
    assign r0_if.rdata  = ram_dout_i;
    assign r1_if.rdata  = ram_dout_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed vector table, reset sequences, randomized run vs reference model.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_if      (r0_if),
        .r1_if      (r1_if),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    // Behavioural single-port RAM: registered read, output holds on write cycles
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        r0_if.req = q0; r0_if.we = w0; r0_if.addr = a0; r0_if.wdata = d0;
        r1_if.req = q1; r1_if.we = w1; r1_if.addr = a1; r1_if.wdata = d1;
    endtask

    function automatic logic [1:0] gnt_v();
        return {r1_if.gnt, r0_if.gnt};
    endfunction

    function automatic logic [1:0] rv_v();
        return {r1_if.rvalid, r0_if.rvalid};
    endfunction

    typedef struct {
        logic q0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic q1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic [1:0] gnt; logic [1:0] rv; logic [DW-1:0] rd;
        logic we; logic [AW-1:0] addr; logic [DW-1:0] din;
    } vec_t;

    function automatic vec_t mk(logic q0, logic w0, int a0, int d0, logic q1, logic w1, int a1, int d1,
                                logic [1:0] gnt, logic [1:0] rv, int rd, logic we, int addr, int din);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
        v.q1 = q1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1);
        v.gnt = gnt; v.rv = rv; v.rd = DW'(rd);
        v.we = we; v.addr = AW'(addr); v.din = DW'(din);
        return v;
    endfunction

    vec_t tbl [$];

    // Reference-model state for the randomized phase
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            prio;
    int            exp_tag;
    logic [DW-1:0] exp_data;
    bit            act   [2];
    bit            we_h  [2];
    int            adr_h [2];
    int            dat_h [2];

    initial begin
        // Both requesting while reset is held: no grant, no rvalid, no write
        rst = 1'b1;
        drive(1'b1, 1'b0, 10'd1, 8'h00, 1'b1, 1'b0, 10'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst gnt", gnt_v(), 2'b00);
            chk("rst rvalid", rv_v(), 2'b00);
            chk("rst ram_we", ram_we, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("first contention R0 wins", gnt_v(), 2'b01);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 10'd2, 8'h00);
        #1 chk("held R1 granted", gnt_v(), 2'b10);
        chk("rvalid after R0 read", rv_v(), 2'b01);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
        #1 chk("rvalid after R1 read", rv_v(), 2'b10);

        // Directed vector table, one row per cycle
        tbl.push_back(mk(0,0,0,0,       0,0,0,0,       2'b00, 2'b00, 0,    0, 0, 0));
        tbl.push_back(mk(1,1,5,8'hA5,   0,0,0,0,       2'b01, 2'b00, 0,    1, 5, 8'hA5));
        tbl.push_back(mk(1,0,5,0,       0,0,0,0,       2'b01, 2'b00, 0,    0, 5, 0));
        tbl.push_back(mk(0,0,0,0,       0,0,0,0,       2'b00, 2'b01, 8'hA5,0, 0, 0));
        tbl.push_back(mk(1,1,1,8'h11,   0,0,0,0,       2'b01, 2'b00, 0,    1, 1, 8'h11));
        tbl.push_back(mk(0,0,0,0,       1,1,2,8'h22,   2'b10, 2'b00, 0,    1, 2, 8'h22));
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b01, 2'b00, 0,    0, 1, 0));
`ifdef BPA_FIXED_PRIO_EN
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b01, 2'b01, 8'h11,0, 1, 0));
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b01, 2'b01, 8'h11,0, 1, 0));
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b01, 2'b01, 8'h11,0, 1, 0));
        tbl.push_back(mk(0,0,0,0,       1,0,2,0,       2'b10, 2'b01, 8'h11,0, 2, 0));
`else
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b10, 2'b01, 8'h11,0, 2, 0));
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b01, 2'b10, 8'h22,0, 1, 0));
        tbl.push_back(mk(1,0,1,0,       1,0,2,0,       2'b10, 2'b01, 8'h11,0, 2, 0));
        tbl.push_back(mk(0,0,0,0,       1,0,2,0,       2'b10, 2'b10, 8'h22,0, 2, 0));
`endif
        tbl.push_back(mk(0,0,0,0,       1,1,3,8'h3C,   2'b10, 2'b10, 8'h22,1, 3, 8'h3C));
        tbl.push_back(mk(1,0,3,0,       0,0,0,0,       2'b01, 2'b00, 0,    0, 3, 0));
        tbl.push_back(mk(0,0,0,0,       0,0,0,0,       2'b00, 2'b01, 8'h3C,0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0,   0,0,0,0,       2'b00, 2'b00, 0,    0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].q0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].q1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("row%0d gnt", i), gnt_v(), tbl[i].gnt);
            chk($sformatf("row%0d rvalid", i), rv_v(), tbl[i].rv);
            chk($sformatf("row%0d ram_we", i), ram_we, tbl[i].we);
            chk($sformatf("row%0d ram_addr", i), ram_addr, tbl[i].addr);
            chk($sformatf("row%0d ram_din", i), ram_din, tbl[i].din);
            if (tbl[i].rv != 2'b00) chk($sformatf("row%0d rdata", i), r0_if.rdata, tbl[i].rd);
        end

        // Reset in the cycle after a granted R1 read drops its rvalid
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 10'd2, 8'h00);
        #1 chk("pre-reset R1 gnt", gnt_v(), 2'b10);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
        #1 chk("pre-reset r1_rvalid", r1_if.rvalid, 1'b1);
        rst = 1'b1;
        #1 chk("r1_rvalid dropped on rst", r1_if.rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("no rvalid after release", rv_v(), 2'b00);
            @(negedge clk);
        end

        // R0 wins last, then reset with both requests held: pointer must return to R0
        drive(1'b1, 1'b0, 10'd1, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
        #1 chk("R0 alone gnt", gnt_v(), 2'b01);
        @(negedge clk);
        drive(1'b1, 1'b0, 10'd1, 8'h00, 1'b1, 1'b0, 10'd2, 8'h00);
        rst = 1'b1;
        #1 chk("rst kills r0_rvalid", rv_v(), 2'b00);
        chk("rst forces gnt low", gnt_v(), 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post-reset R0 favoured", gnt_v(), 2'b01);
        chk("no rvalid across reset", rv_v(), 2'b00);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 10'd2, 8'h00);
        #1 chk("post-reset R1 next", gnt_v(), 2'b10);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
        @(negedge clk);

        // Randomized run against a transaction-level model (pointer is 0, nothing pending)
        prio    = 0;
        exp_tag = -1;
        exp_data = 8'h00;
        for (int k = 0; k < 2; k++) act[k] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int win;
            for (int k = 0; k < 2; k++) begin
                if (!act[k]) begin
                    if (c < 16) begin
                        if (k == 0) begin
                            act[0] = 1'b1; we_h[0] = 1'b1; adr_h[0] = 16 + c; dat_h[0] = int'($urandom_range(0, 255));
                        end
                    end else if ($urandom_range(0, 99) < 60) begin
                        act[k]   = 1'b1;
                        we_h[k]  = ($urandom_range(0, 2) == 0);
                        adr_h[k] = 16 + int'($urandom_range(0, 15));
                        dat_h[k] = int'($urandom_range(0, 255));
                    end
                end
            end
            drive(act[0], we_h[0], AW'(adr_h[0]), DW'(dat_h[0]), act[1], we_h[1], AW'(adr_h[1]), DW'(dat_h[1]));
            #1;
            if (act[0] && act[1]) begin
`ifdef BPA_FIXED_PRIO_EN
                win = 0;
`else
                win = prio;
`endif
            end else if (act[0]) win = 0;
            else if (act[1]) win = 1;
            else win = -1;

            chk("rand gnt", gnt_v(), (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00);
            chk("rand rvalid", rv_v(), (exp_tag == 0) ? 2'b01 : (exp_tag == 1) ? 2'b10 : 2'b00);
            if (exp_tag >= 0) chk("rand rdata", (exp_tag == 0) ? r0_if.rdata : r1_if.rdata, exp_data);
            if (win >= 0) begin
                chk("rand ram_we", ram_we, we_h[win]);
                chk("rand ram_addr", ram_addr, adr_h[win]);
                chk("rand ram_din", ram_din, dat_h[win]);
                if (we_h[win]) begin
                    shadow[adr_h[win]] = DW'(dat_h[win]);
                    exp_tag = -1;
                end else begin
                    exp_tag  = win;
                    exp_data = shadow[adr_h[win]];
                end
                prio = 1 - win;
                act[win] = 1'b0;
            end else begin
                chk("rand idle ram_we", ram_we, 1'b0);
                chk("rand idle ram_addr", ram_addr, 10'd0);
                exp_tag = -1;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
